// File: rtl/y86_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// y86_pkg: status/icode/register constants and retire-monitor FSM state type
// Rev 1.0
// ----------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] SAOK         = 4'd1;
  localparam logic [3:0] SHLT         = 4'd2;
  localparam logic [3:0] SADR         = 4'd3;
  localparam logic [3:0] SINS         = 4'd4;
  localparam logic [3:0] STAT_TIMEOUT = 4'hF;

  localparam logic [3:0] IHALT        = 4'd0;
  localparam logic [3:0] INOP         = 4'd1;

  localparam logic [3:0] RNONE        = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } mon_state_e;

  function automatic logic is_terminal(input logic [3:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/y86_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// y86_sat_counter: adds 0..2 per enabled cycle, sticks at all-ones
// Rev 1.0
// ----------------------------------------------------------------------------
module y86_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] q
);

  logic [W:0] w_sum;

  // One extra bit catches the carry so an add of 2 near the top saturates too.
  assign w_sum = {1'b0, q} + (W + 1)'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/y86_retire_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// y86_retire_monitor: W-stage retire statistics, termination capture and watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module y86_retire_monitor
  import y86_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic             W_stall,
  input  logic             F_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] nop_cnt,
  output logic [CNT_W-1:0] regwr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [3:0]       final_stat,
  output logic             timeout,
  output logic             done
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WDOG_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int N_CNT   = 6;

  mon_state_e         r_state;
  mon_state_e         w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [WDOG_W-1:0]  r_idle_cnt;

  logic w_in_run;
  logic w_terminal;
  logic w_slot_valid;
  logic w_retire;
  logic w_nop;
  logic w_wdog_exp;
  logic w_drain_last;
  logic [1:0] w_regwr_inc;

  logic [1:0]       w_inc [N_CNT];
  logic [CNT_W-1:0] w_cnt [N_CNT];

  assign w_in_run     = (r_state == ST_RUN);
  assign w_terminal   = w_in_run && is_terminal(W_stat);
  assign w_slot_valid = !W_stall && (W_stat == SAOK);
  assign w_retire     = w_slot_valid && (W_icode != INOP);
  assign w_nop        = w_slot_valid && (W_icode == INOP);
  assign w_regwr_inc  = {1'b0, w_slot_valid && (W_dstE != RNONE)}
                      + {1'b0, w_slot_valid && (W_dstM != RNONE)};

  assign w_wdog_exp   = (WDOG_CYCLES != 0) && w_in_run && !w_slot_valid
                      && (r_idle_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign w_drain_last = (DRAIN_CYCLES == 0)
                      || (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

  // Counter order: cycle, retired, nop, regwr, stall, bubble.
  assign w_inc[0] = 2'd1;
  assign w_inc[1] = {1'b0, w_retire};
  assign w_inc[2] = {1'b0, w_nop};
  assign w_inc[3] = w_regwr_inc;
  assign w_inc[4] = {1'b0, F_stall};
  assign w_inc[5] = {1'b0, D_bubble || E_bubble};

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    y86_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .en    (w_in_run),
      .inc   (w_inc[gi]),
      .q     (w_cnt[gi])
    );
  end

  assign cycle_cnt   = w_cnt[0];
  assign retired_cnt = w_cnt[1];
  assign nop_cnt     = w_cnt[2];
  assign regwr_cnt   = w_cnt[3];
  assign stall_cnt   = w_cnt[4];
  assign bubble_cnt  = w_cnt[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Terminal status is checked before the watchdog so it wins a same-cycle tie.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (w_terminal) begin
          w_state_nxt = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else if (w_wdog_exp) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (w_drain_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_DONE;
    endcase
    if (clear) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_comb begin
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_stat  <= SAOK;
      timeout     <= 1'b0;
      r_idle_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (clear) begin
      final_stat  <= SAOK;
      timeout     <= 1'b0;
      r_idle_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_terminal) begin
        final_stat <= W_stat;
      end else if (w_wdog_exp) begin
        final_stat <= STAT_TIMEOUT;
        timeout    <= 1'b1;
      end
      if (w_in_run) begin
        r_idle_cnt  <= w_slot_valid ? '0 : r_idle_cnt + 1'b1;
        r_drain_cnt <= '0;
      end else if ((r_state == ST_DRAIN) && !w_drain_last) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_retire_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_y86_retire_monitor: directed vectors against a wide and a 4-bit-counter instance
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_y86_retire_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [3:0] W_icode, W_stat, W_dstE, W_dstM;
  logic       W_stall, F_stall, D_bubble, E_bubble;

  logic [31:0] cycle_cnt, retired_cnt, nop_cnt, regwr_cnt, stall_cnt, bubble_cnt;
  logic [3:0]  final_stat;
  logic        timeout, done;

  logic [3:0] cycle_s, retired_s, nop_s, regwr_s, stall_s, bubble_s;
  logic [3:0] final_stat_s;
  logic       timeout_s, done_s;

  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  y86_retire_monitor #(.CNT_W(32), .DRAIN_CYCLES(4), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .W_icode(W_icode), .W_stat(W_stat), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_stall(W_stall), .F_stall(F_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .nop_cnt(nop_cnt),
    .regwr_cnt(regwr_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .final_stat(final_stat), .timeout(timeout), .done(done)
  );

  y86_retire_monitor #(.CNT_W(4), .DRAIN_CYCLES(4), .WDOG_CYCLES(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .W_icode(W_icode), .W_stat(W_stat), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_stall(W_stall), .F_stall(F_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .cycle_cnt(cycle_s), .retired_cnt(retired_s), .nop_cnt(nop_s),
    .regwr_cnt(regwr_s), .stall_cnt(stall_s), .bubble_cnt(bubble_s),
    .final_stat(final_stat_s), .timeout(timeout_s), .done(done_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input logic [3:0] ic, input logic [3:0] st,
                          input logic [3:0] de, input logic [3:0] dm, input logic stall);
    W_icode = ic;
    W_stat  = st;
    W_dstE  = de;
    W_dstM  = dm;
    W_stall = stall;
  endtask

  task automatic idle_in();
    set_slot(4'd1, 4'd1, 4'hF, 4'hF, 1'b0);
    F_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] ics [5];
    ics = '{4'd3, 4'd6, 4'd1, 4'd2, 4'd1};
    n_chk  = 0;
    n_fail = 0;

    do_reset();
    check_eq("rst_cycle", cycle_cnt, 32'd0);
    check_eq("rst_retired", retired_cnt, 32'd0);
    check_eq("rst_final_stat", {28'd0, final_stat}, 32'd1);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);

    // Reset mid-run at cycle 37
    repeat (37) tick();
    check_eq("run_cycle37", cycle_cnt, 32'd37);
    check_eq("run_nop37", nop_cnt, 32'd37);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_cycle", cycle_cnt, 32'd0);
    check_eq("async_rst_nop", nop_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("restart_cycle", cycle_cnt, 32'd3);

    // Five slots then halt
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_slot(ics[i], 4'd1, 4'(i), 4'hF, 1'b0);
      tick();
    end
    set_slot(4'd0, 4'd2, 4'hF, 4'hF, 1'b0);
    tick();
    check_eq("halt_final_stat", {28'd0, final_stat}, 32'd2);
    check_eq("halt_retired", retired_cnt, 32'd3);
    check_eq("halt_nop", nop_cnt, 32'd2);
    check_eq("halt_regwr", regwr_cnt, 32'd5);
    check_eq("halt_cycle", cycle_cnt, 32'd6);
    check_eq("halt_done_early", {31'd0, done}, 32'd0);
    idle_in();
    repeat (3) tick();
    check_eq("halt_drain3_done", {31'd0, done}, 32'd0);
    tick();
    check_eq("halt_drain4_done", {31'd0, done}, 32'd1);
    check_eq("halt_frozen_cycle", cycle_cnt, 32'd6);
    check_eq("halt_frozen_nop", nop_cnt, 32'd2);

    // ADR while W is stalled
    do_reset();
    repeat (2) tick();
    set_slot(4'd3, 4'd3, 4'd0, 4'hF, 1'b1);
    tick();
    check_eq("adr_final_stat", {28'd0, final_stat}, 32'd3);
    check_eq("adr_retired", retired_cnt, 32'd0);
    check_eq("adr_nop", nop_cnt, 32'd2);
    check_eq("adr_regwr", regwr_cnt, 32'd0);
    idle_in();
    repeat (3) tick();
    check_eq("adr_drain3_done", {31'd0, done}, 32'd0);
    tick();
    check_eq("adr_done", {31'd0, done}, 32'd1);

    // Watchdog expiry with W held
    do_reset();
    set_slot(4'd1, 4'd1, 4'hF, 4'hF, 1'b1);
    F_stall  = 1'b1;
    D_bubble = 1'b1;
    repeat (7) tick();
    check_eq("wdog7_timeout", {31'd0, timeout}, 32'd0);
    check_eq("wdog7_done", {31'd0, done}, 32'd0);
    tick();
    check_eq("wdog8_timeout", {31'd0, timeout}, 32'd1);
    check_eq("wdog8_final_stat", {28'd0, final_stat}, 32'hF);
    check_eq("wdog8_done", {31'd0, done}, 32'd1);
    check_eq("wdog8_cycle", cycle_cnt, 32'd8);
    check_eq("wdog8_stall", stall_cnt, 32'd8);
    check_eq("wdog8_bubble", bubble_cnt, 32'd8);
    check_eq("wdog8_nop", nop_cnt, 32'd0);
    tick();
    check_eq("wdog_done_frozen", cycle_cnt, 32'd8);

    // Terminal status on the expiry cycle beats the watchdog
    do_reset();
    set_slot(4'd1, 4'd1, 4'hF, 4'hF, 1'b1);
    repeat (7) tick();
    W_stat = 4'd4;
    tick();
    check_eq("tie_final_stat", {28'd0, final_stat}, 32'd4);
    check_eq("tie_timeout", {31'd0, timeout}, 32'd0);
    check_eq("tie_done_early", {31'd0, done}, 32'd0);
    idle_in();
    repeat (4) tick();
    check_eq("tie_done", {31'd0, done}, 32'd1);
    check_eq("tie_timeout_end", {31'd0, timeout}, 32'd0);

    // Saturation on the 4-bit instance
    do_reset();
    set_slot(4'd5, 4'd1, 4'd3, 4'd4, 1'b0);
    repeat (7) tick();
    check_eq("sat_regwr14", {28'd0, regwr_s}, 32'd14);
    check_eq("sat_retired7", {28'd0, retired_s}, 32'd7);
    tick();
    check_eq("sat_regwr_plus2", {28'd0, regwr_s}, 32'd15);
    repeat (12) tick();
    check_eq("sat_retired", {28'd0, retired_s}, 32'd15);
    check_eq("sat_regwr", {28'd0, regwr_s}, 32'd15);
    check_eq("sat_cycle", {28'd0, cycle_s}, 32'd15);
    check_eq("wide_retired20", retired_cnt, 32'd20);
    check_eq("wide_regwr40", regwr_cnt, 32'd40);

    // Clear out of DONE, then a fresh halt
    set_slot(4'd0, 4'd2, 4'hF, 4'hF, 1'b0);
    tick();
    idle_in();
    repeat (4) tick();
    check_eq("pre_clear_done", {31'd0, done}, 32'd1);
    set_slot(4'd6, 4'd1, 4'd2, 4'hF, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_done", {31'd0, done}, 32'd0);
    check_eq("clr_cycle", cycle_cnt, 32'd0);
    check_eq("clr_retired", retired_cnt, 32'd0);
    check_eq("clr_regwr", regwr_cnt, 32'd0);
    check_eq("clr_final_stat", {28'd0, final_stat}, 32'd1);
    check_eq("clr_sat_retired", {28'd0, retired_s}, 32'd0);
    set_slot(4'd0, 4'd2, 4'hF, 4'hF, 1'b0);
    tick();
    check_eq("rehalt_final_stat", {28'd0, final_stat}, 32'd2);
    check_eq("rehalt_cycle", cycle_cnt, 32'd1);
    idle_in();
    repeat (3) tick();
    check_eq("rehalt_drain3_done", {31'd0, done}, 32'd0);
    tick();
    check_eq("rehalt_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
